seq_scan_ctrl: RTL and testbench

//   Streams parallel words MSB-first, one bit per clock, through a serial pattern-match core.

---
 rtl/seq_scan_pkg.sv | 15 +
 rtl/seq_scan_if.sv | 24 ++
 rtl/seq_scan_core.sv | 41 ++++
 rtl/seq_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and default parameters for the serial pattern-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } scan_state_e;

  localparam int         DEF_DATA_W  = 8;
  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_scan_if.sv
// Word-in / result-out handshake bundle for seq_scan_ctrl.
interface seq_scan_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic              found;
  logic [CNT_W-1:0]  first_pos;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, match_cnt, found, first_pos
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, match_cnt, found, first_pos
  );
endinterface

// File: rtl/seq_scan_core.sv
// Serial pattern matcher: PAT_W-bit shift history plus fill counter; match is a
// Moore output decoded from registers only.
module seq_scan_core #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic [PAT_W:0]    hist_ext_s;

  assign hist_ext_s = {hist_r, bit_in};

  // History shift register and saturating fill count; clr wins over shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (clr) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (shift_en) begin
      hist_r <= hist_ext_s[PAT_W-1:0];
      if (fill_r != FILL_W'(PAT_W)) begin
        fill_r <= fill_r + FILL_W'(1);
      end
    end
  end

  // Fill qualification keeps the zeroed history from matching leading-zero patterns.
  assign match = (fill_r == FILL_W'(PAT_W)) && (hist_r == PATTERN);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-serialising controller around seq_scan_core. Define SEQ_SCAN_CARRY_EN to
// keep core history across words so boundary-straddling matches are counted.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int               DATA_W  = DEF_DATA_W,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  seq_scan_if.slave    bus
);
  scan_state_e       state_r, state_nxt_s;
  logic [DATA_W-1:0] word_r;
  logic [CNT_W-1:0]  idx_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  first_pos_r;
  logic              found_r;
  logic              in_ready_r;
  logic              out_valid_r;

  logic              accept_s;
  logic              shift_en_s;
  logic              count_en_s;
  logic              clr_s;
  logic              core_match_s;
  logic [CNT_W-1:0]  pos_s;

  // Next-state and per-cycle strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    shift_en_s  = 1'b0;
    count_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        // idx 0 sees the core state from before this word's first bit.
        count_en_s = (idx_r != CNT_W'(0));
        if (idx_r == CNT_W'(DATA_W - 1)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DRAIN: begin
        count_en_s  = 1'b1;
        state_nxt_s = REPORT;
      end
      REPORT: begin
        if (out_valid_r && bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REPORT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef SEQ_SCAN_CARRY_EN
  assign clr_s = 1'b0;
`else
  assign clr_s = accept_s;
`endif

  // The match being counted belongs to the bit shifted one edge earlier.
  assign pos_s = idx_r - CNT_W'(1);

  // State register and registered handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == REPORT);
    end
  end

  // Word register, bit index, match count and first-hit position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r      <= '0;
      idx_r       <= '0;
      count_r     <= '0;
      first_pos_r <= '0;
      found_r     <= 1'b0;
    end else if (accept_s) begin
      word_r      <= bus.in_data;
      idx_r       <= '0;
      count_r     <= '0;
      first_pos_r <= '0;
      found_r     <= 1'b0;
    end else begin
      if (shift_en_s) begin
        word_r <= word_r << 1;
        idx_r  <= idx_r + CNT_W'(1);
      end
      if (count_en_s && core_match_s) begin
        count_r <= count_r + CNT_W'(1);
        found_r <= 1'b1;
        if (!found_r) begin
          first_pos_r <= pos_s;
        end
      end
    end
  end

  seq_scan_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .bit_in   (word_r[DATA_W-1]),
    .match    (core_match_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.match_cnt = count_r;
  assign bus.found     = found_r;
  assign bus.first_pos = first_pos_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomised self-checking bench for seq_scan_ctrl against a sliding-window
// reference model (two instances: PATTERN 1011 and 0011).
module tb_seq_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_scan_if #(.DATA_W(8), .CNT_W(4)) bus_a ();
  seq_scan_if #(.DATA_W(8), .CNT_W(4)) bus_b ();

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .PATTERN(4'b0011), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  logic       iv [2];
  logic [7:0] id [2];
  logic       ordy [2];
  assign bus_a.in_valid  = iv[0];
  assign bus_a.in_data   = id[0];
  assign bus_a.out_ready = ordy[0];
  assign bus_b.in_valid  = iv[1];
  assign bus_b.in_data   = id[1];
  assign bus_b.out_ready = ordy[1];

  wire [1:0] rdy_w = {bus_b.in_ready, bus_a.in_ready};
  wire [1:0] vld_w = {bus_b.out_valid, bus_a.out_valid};
  wire [1:0] fnd_w = {bus_b.found, bus_a.found};
  wire [3:0] cnt_w [2];
  wire [3:0] pos_w [2];
  assign cnt_w[0] = bus_a.match_cnt;
  assign cnt_w[1] = bus_b.match_cnt;
  assign pos_w[0] = bus_a.first_pos;
  assign pos_w[1] = bus_b.first_pos;

  // Reference bit history per instance (sliding window of last 4 received bits).
  bit hist_a[$];
  bit hist_b[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ref_scan(input logic [7:0] d, input int s, output int cnt, output int fpos);
    bit h[$];
    logic [3:0] pat;
    logic [3:0] win;
    h   = (s == 1) ? hist_b : hist_a;
    pat = (s == 1) ? 4'b0011 : 4'b1011;
`ifndef SEQ_SCAN_CARRY_EN
    h.delete();
`endif
    cnt  = 0;
    fpos = 0;
    for (int i = 0; i < 8; i++) begin
      h.push_back(d[7-i]);
      if (h.size() > 4) void'(h.pop_front());
      if (h.size() == 4) begin
        win = {h[0], h[1], h[2], h[3]};
        if (win == pat) begin
          if (cnt == 0) fpos = i;
          cnt++;
        end
      end
    end
    if (s == 1) hist_b = h;
    else hist_a = h;
  endtask

  task automatic xfer(input int s, input logic [7:0] d, input int stall);
    int ecnt, efp, n;
    ref_scan(d, s, ecnt, efp);
    @(negedge clk);
    n = 0;
    while (!rdy_w[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("in_ready_wait", 32'(rdy_w[s]), 32'd1);
    iv[s] = 1'b1;
    id[s] = d;
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    id[s] = 8'($urandom);
    check_val("busy_in_ready", 32'(rdy_w[s]), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!vld_w[s] && n < 40);
    check_val("latency", n, 32'd9);
    check_val("match_cnt", 32'(cnt_w[s]), 32'(ecnt));
    check_val("found", 32'(fnd_w[s]), 32'(ecnt != 0));
    check_val("first_pos", 32'(pos_w[s]), 32'(efp));
    repeat (stall) begin
      @(negedge clk);
      iv[s] = 1'b1;
      check_val("stall_valid", 32'(vld_w[s]), 32'd1);
      check_val("stall_cnt", 32'(cnt_w[s]), 32'(ecnt));
      check_val("stall_pos", 32'(pos_w[s]), 32'(efp));
      check_val("stall_in_ready", 32'(rdy_w[s]), 32'd0);
    end
    @(negedge clk);
    iv[s]   = 1'b0;
    ordy[s] = 1'b1;
    @(posedge clk);
    #1;
    ordy[s] = 1'b0;
    check_val("post_out_valid", 32'(vld_w[s]), 32'd0);
    check_val("post_in_ready", 32'(rdy_w[s]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0;
      id[i] = 8'h00;
      ordy[i] = 1'b0;
    end
    #12;
    check_val("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check_val("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check_val("rst_cnt", 32'(bus_a.match_cnt), 32'd0);
    check_val("rst_found", 32'(bus_a.found), 32'd0);
    check_val("rst_pos", 32'(bus_a.first_pos), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases on the 1011 instance.
    xfer(0, 8'b1011_0110, 0);
    xfer(0, 8'h00, 0);
    xfer(0, 8'b1011_0110, 5);
    xfer(0, 8'b0000_0101, 0);
    xfer(0, 8'b1000_0000, 1);
    xfer(0, 8'b1011_0111, 0);
    xfer(0, 8'hFF, 2);

    // Reset in the middle of a word.
    @(negedge clk);
    iv[0] = 1'b1;
    id[0] = 8'b1011_0110;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #3;
    check_val("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check_val("mid_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    hist_a.delete();
    hist_b.delete();
    repeat (12) @(negedge clk);
    check_val("no_result_after_rst", 32'(bus_a.out_valid), 32'd0);
    xfer(0, 8'b1011_0110, 0);

    // Leading-zero pattern on the 0011 instance.
    xfer(1, 8'b1100_0000, 0);
    xfer(1, 8'b0011_0000, 1);

    // Randomised words with random consumer stalls.
    for (int k = 0; k < 24; k++) begin
      xfer(0, 8'($urandom), int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 8; k++) begin
      xfer(1, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
